// File: rtl/reg_file_8x16.sv
// reg_file_8x16: eight-entry general-purpose register file with r0 tied to
// zero, two combinational operand read ports, a debug read port that always
// shows stored contents, and a registered count of committed writes.
module reg_file_8x16 #(
   parameter int DATA_W = 16,
   parameter bit BYPASS = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [2:0]        wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [2:0]        ra1,
   input  logic [2:0]        ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [2:0]        dbg_a,
   output logic [DATA_W-1:0] dbg_d,
   output logic [7:0]        wr_cnt
);

   // Only r1..r7 carry storage; r0 exists solely as a constant in the read view.
   logic [DATA_W-1:0] regs [1:7];
   logic [DATA_W-1:0] view [8];
   logic              commit;
   logic              hit1;
   logic              hit2;

   // A write commits only when enabled, aimed at a real register and not in reset.
   // Comparing wa only when we is high keeps an undriven wa from disturbing state.
   always_comb begin
      commit = 1'b0;
      if (we && !rst) begin
         commit = (wa != 3'd0);
      end
   end

   // Register storage: reset clears r1..r7, otherwise the addressed entry loads wd.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         for (int i = 1; i < 8; i++) begin
            if (wa == 3'(i)) begin
               regs[i] <= wd;
            end
         end
      end
   end

   // Committed-write counter; wraps naturally at 8 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt <= 8'd0;
      end else if (commit) begin
         wr_cnt <= wr_cnt + 8'd1;
      end
   end

   // Flat eight-entry view of the file with entry 0 reading as zero.
   always_comb begin
      view[0] = '0;
      for (int i = 1; i < 8; i++) begin
         view[i] = regs[i];
      end
   end

   // Per-port forwarding match; commit already excludes address 0 and reset.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      if (BYPASS && commit) begin
         hit1 = (ra1 == wa);
         hit2 = (ra2 == wa);
      end
   end

   // Operand reads, optionally forwarding the in-flight write data.
   always_comb begin
      rd1 = view[ra1];
      rd2 = view[ra2];
      if (hit1) begin
         rd1 = wd;
      end
      if (hit2) begin
         rd2 = wd;
      end
   end

   // Debug read shows stored contents only, never the forwarded value.
   always_comb begin
      dbg_d = view[dbg_a];
   end

endmodule

// File: tb/tb_reg_file_8x16.sv
// tb_reg_file_8x16: directed checks of the register file, with one instance
// built without forwarding and one with forwarding, sharing all inputs.
module tb_reg_file_8x16;

   logic        clk;
   logic        rst;
   logic        we;
   logic [2:0]  wa;
   logic [15:0] wd;
   logic [2:0]  ra1;
   logic [2:0]  ra2;
   logic [2:0]  dbg_a;

   logic [15:0] rd1_n, rd2_n, dbg_n;
   logic [7:0]  cnt_n;
   logic [15:0] rd1_b, rd2_b, dbg_b;
   logic [7:0]  cnt_b;

   int errors = 0;
   int checks = 0;

   reg_file_8x16 #(.DATA_W(16), .BYPASS(1'b0)) dut_nobyp (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
      .dbg_a(dbg_a), .dbg_d(dbg_n), .wr_cnt(cnt_n)
   );

   reg_file_8x16 #(.DATA_W(16), .BYPASS(1'b1)) dut_byp (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .dbg_a(dbg_a), .dbg_d(dbg_b), .wr_cnt(cnt_b)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one write on the next edge and release we just after it.
   task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] data);
      @(negedge clk);
      we = 1'b1;
      wa = addr;
      wd = data;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      we  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         dbg_a = 3'(a);
         #1;
         checks++;
         if (dbg_n !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_dbg_nobyp a=%0d got=%h exp=0000", a, dbg_n);
         end
         checks++;
         if (dbg_b !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_dbg_byp a=%0d got=%h exp=0000", a, dbg_b);
         end
      end
      checks++;
      if (cnt_n !== 8'd0 || cnt_b !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0", cnt_n, cnt_b);
      end
   endtask

   task automatic test_write_read;
      applyStimulus(3'd3, 16'hA5A5);
      applyStimulus(3'd5, 16'h1234);
      ra1 = 3'd3;
      ra2 = 3'd5;
      #1;
      checks++;
      if (rd1_n !== 16'hA5A5 || rd1_b !== 16'hA5A5) begin
         errors++;
         $display("[TB] FAIL wr_rd1 got=%h/%h exp=a5a5", rd1_n, rd1_b);
      end
      checks++;
      if (rd2_n !== 16'h1234 || rd2_b !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL wr_rd2 got=%h/%h exp=1234", rd2_n, rd2_b);
      end
      checks++;
      if (cnt_n !== 8'd2 || cnt_b !== 8'd2) begin
         errors++;
         $display("[TB] FAIL wr_cnt got=%0d/%0d exp=2", cnt_n, cnt_b);
      end
   endtask

   task automatic test_r0;
      applyStimulus(3'd0, 16'hFFFF);
      ra1 = 3'd0;
      #1;
      checks++;
      if (rd1_n !== 16'h0000 || rd1_b !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL r0_read got=%h/%h exp=0000", rd1_n, rd1_b);
      end
      checks++;
      if (cnt_n !== 8'd2 || cnt_b !== 8'd2) begin
         errors++;
         $display("[TB] FAIL r0_cnt got=%0d/%0d exp=2", cnt_n, cnt_b);
      end
   endtask

   task automatic test_read_during_write;
      applyStimulus(3'd2, 16'h0011);
      @(negedge clk);
      we    = 1'b1;
      wa    = 3'd2;
      wd    = 16'h0022;
      ra1   = 3'd2;
      ra2   = 3'd2;
      dbg_a = 3'd2;
      #1;
      checks++;
      if (rd1_n !== 16'h0011) begin
         errors++;
         $display("[TB] FAIL rdw_pre_nobyp got=%h exp=0011", rd1_n);
      end
      checks++;
      if (rd1_b !== 16'h0022 || rd2_b !== 16'h0022) begin
         errors++;
         $display("[TB] FAIL rdw_pre_byp got=%h/%h exp=0022", rd1_b, rd2_b);
      end
      checks++;
      if (dbg_b !== 16'h0011) begin
         errors++;
         $display("[TB] FAIL rdw_dbg_byp got=%h exp=0011", dbg_b);
      end
      @(posedge clk);
      #1;
      we = 1'b0;
      #1;
      checks++;
      if (rd1_n !== 16'h0022 || rd1_b !== 16'h0022) begin
         errors++;
         $display("[TB] FAIL rdw_post got=%h/%h exp=0022", rd1_n, rd1_b);
      end
      checks++;
      if (cnt_n !== 8'd4 || cnt_b !== 8'd4) begin
         errors++;
         $display("[TB] FAIL rdw_cnt got=%0d/%0d exp=4", cnt_n, cnt_b);
      end
   endtask

   task automatic test_reset_vs_write;
      @(negedge clk);
      rst = 1'b1;
      we  = 1'b1;
      wa  = 3'd4;
      wd  = 16'hBEEF;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      we    = 1'b0;
      dbg_a = 3'd4;
      ra1   = 3'd3;
      #1;
      checks++;
      if (dbg_n !== 16'h0000 || dbg_b !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL rstwr_r4 got=%h/%h exp=0000", dbg_n, dbg_b);
      end
      checks++;
      if (rd1_n !== 16'h0000 || rd1_b !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL rstwr_r3 got=%h/%h exp=0000", rd1_n, rd1_b);
      end
      checks++;
      if (cnt_n !== 8'd0 || cnt_b !== 8'd0) begin
         errors++;
         $display("[TB] FAIL rstwr_cnt got=%0d/%0d exp=0", cnt_n, cnt_b);
      end
   endtask

   task automatic test_counter_wrap;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(3'((i % 7) + 1), 16'(i * 3 + 1));
      end
      checks++;
      if (cnt_n !== 8'd0 || cnt_b !== 8'd0) begin
         errors++;
         $display("[TB] FAIL wrap_cnt got=%0d/%0d exp=0", cnt_n, cnt_b);
      end
      ra1 = 3'd4;
      ra2 = 3'd3;
      #1;
      checks++;
      if (rd1_n !== 16'h02FE || rd2_n !== 16'h02FB) begin
         errors++;
         $display("[TB] FAIL wrap_data got=%h/%h exp=02fe/02fb", rd1_n, rd2_n);
      end
      // Undriven write address with we low must leave everything alone.
      @(negedge clk);
      we = 1'b0;
      wa = 3'bxxx;
      wd = 16'hDEAD;
      @(posedge clk);
      #1;
      checks++;
      if (rd1_b !== 16'h02FE || rd2_b !== 16'h02FB || cnt_b !== 8'd0) begin
         errors++;
         $display("[TB] FAIL xaddr got=%h/%h cnt=%0d exp=02fe/02fb cnt=0", rd1_b, rd2_b, cnt_b);
      end
      applyStimulus(3'd6, 16'h5555);
      ra1 = 3'd6;
      #1;
      checks++;
      if (cnt_n !== 8'd1 || cnt_b !== 8'd1) begin
         errors++;
         $display("[TB] FAIL wrap_plus1 got=%0d/%0d exp=1", cnt_n, cnt_b);
      end
      checks++;
      if (rd1_n !== 16'h5555) begin
         errors++;
         $display("[TB] FAIL wrap_last_data got=%h exp=5555", rd1_n);
      end
   endtask

   // Sequence the scenarios and report.
   initial begin
      rst   = 1'b0;
      we    = 1'b0;
      wa    = 3'd0;
      wd    = 16'h0000;
      ra1   = 3'd0;
      ra2   = 3'd0;
      dbg_a = 3'd0;
      test_reset();
      test_write_read();
      test_r0();
      test_read_during_write();
      test_reset_vs_write();
      test_counter_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_8x16.md
# reg_file_8x16

Eight-entry, 16-bit general-purpose register file for the single-cycle CPU datapath. It consumes the 3-bit write-register address chosen by the destination-select 4:1 multiplexer, together with the write-back data and the write enable. It supplies two combinational read operands to the ALU stage in the same cycle. A debug read port and a committed-write counter support bench and board-level observation.

## Interface
- `DATA_W`, 16: register width in bits.
- `BYPASS`, 0: read-during-write policy. 0 returns the old value; 1 forwards the write data to a matching read port.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high. It is sampled only on the rising edge of `clk`.
- `we` input 1: write enable from the control unit.
- `wa` input 3: write address, driven by the destination-select mux output.
- `wd` input DATA_W: write-back data.
- `ra1` input 3: read address, port 1 (rs).
- `ra2` input 3: read address, port 2 (rt).
- `rd1` output DATA_W: read data, port 1, combinational.
- `rd2` output DATA_W: read data, port 2, combinational.
- `dbg_a` input 3: debug read address.
- `dbg_d` output DATA_W: debug read data, combinational. It never uses the bypass path.
- `wr_cnt` output 8: count of committed writes, registered.

## Operation
- Storage: registers r0..r7, each DATA_W bits.
- r0 is hard-wired to zero:
  - Writes to `wa`=0 are discarded and do not increment `wr_cnt`.
  - Any read of address 0 returns 0, including under bypass.
- Commit condition: `we`=1, `wa`≠0 and `rst`=0 at the rising edge. On commit, r[`wa`] ← `wd` and `wr_cnt` ← `wr_cnt`+1.
- `wr_cnt` is 8-bit modular and wraps from 255 to 0.
- Reset: on a rising edge with `rst`=1:
  - r1..r7 ← 0 and `wr_cnt` ← 0.
  - Any simultaneous write is suppressed.
  - `rst` wins over `we` unconditionally.
- Read ports: `rdN` = r[`raN`], combinational from the current register contents and address.
- Bypass (`BYPASS`=1 only): if `we`=1, `wa`≠0, `rst`=0 and `raN`==`wa`, then `rdN` = `wd`. Each port evaluates this condition independently. Both ports may bypass in the same cycle.
- With `BYPASS`=0, a read of the register being written returns the pre-edge value until the edge, then the new value.
- X on `wa` while `we`=0 must not corrupt any register.

## Timing
- Write latency: 1 edge. The value is visible on the read ports immediately after the committing edge.
- Read latency: 0 cycles (combinational). This is required for single-cycle operation.
- Reset: 1 edge. All outputs (`rd1`, `rd2`, `dbg_d`) read 0 for every address after the reset edge. `wr_cnt`=0 after the reset edge.
- Before the first reset edge, register and counter contents are undefined. The bench must reset first.
- Reset asserted mid-program clears state on that edge. Operation resumes on the first edge with `rst`=0.
- Only one write per cycle. There are no back-pressure or handshake signals.

## Test plan
- Reset: `rst`=1 for 1 edge, then sweep `dbg_a` 0..7 -> `dbg_d`=0 for all addresses and `wr_cnt`=0.
- Write/read: write r3←16'hA5A5 and r5←16'h1234 on consecutive edges, then set `ra1`=3 and `ra2`=5 -> `rd1`=A5A5, `rd2`=1234, `wr_cnt`=2.
- r0 protection: `we`=1, `wa`=0, `wd`=16'hFFFF -> `rd1`(`ra1`=0)=0 after the edge and `wr_cnt` unchanged.
- Read-during-write: r2 holds 16'h0011; set `we`=1, `wa`=2, `wd`=16'h0022, `ra1`=`ra2`=2.
  - `BYPASS`=0: `rd1`=0011 before the edge and 0022 after it.
  - `BYPASS`=1: `rd1`=`rd2`=0022 before the edge; `dbg_d`(`dbg_a`=2)=0011 before the edge.
- Reset vs write: `rst`=1 with `we`=1, `wa`=4, `wd`=16'hBEEF -> r4=0 and `wr_cnt`=0 after the edge.
- Counter wrap: 256 committed writes -> `wr_cnt`=0. One further write -> `wr_cnt`=1.
